// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// One-bit full adder built from two half-adder stages and an OR; purely combinational.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p1;
  logic g1;
  logic g2;

  // First half adder on the operand bits, second on the partial sum and carry-in.
  assign p1 = x ^ y;
  assign g1 = x & y;
  assign s  = p1 ^ ci;
  assign g2 = p1 & ci;
  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry register, LSB first,
// one bit per clock, with a one-cycle done pulse when {cout, sum} is updated.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             cell_s;
  logic             cell_co;
  logic [WIDTH-1:0] psum_shifted;

  full_adder_cell u_cell (
    .x  (a_sr_q[0]),
    .y  (b_sr_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // Partial sum with this edge's bit inserted at the top; valid for WIDTH=1 too.
  always_comb begin
    psum_shifted            = psum_q >> 1;
    psum_shifted[WIDTH-1]   = cell_s;
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        psum_d  = psum_shifted;
        carry_d = cell_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = psum_shifted;
          cout_d  = cell_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign ready = (state_q == IDLE) || (state_q == DONE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=4 and WIDTH=3
// against plain integer addition.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, busy4, cout4, done4;
  logic [3:0] sum4;

  logic       start3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       ready3, busy3, cout3, done3;
  logic [2:0] sum3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .ready(ready4), .busy(busy4), .sum(sum4), .cout(cout4), .done(done4)
  );

  serial_adder #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .ready(ready3), .busy(busy3), .sum(sum3), .cout(cout3), .done(done3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Waits for done, then checks latency, busy length and the result.
  task automatic finish4(input string tag, input int unsigned expected);
    int lat = 0;
    int busy_cnt = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy_cycles"}, busy_cnt, 4);
    check({tag, "_result"}, {cout4, sum4}, expected[4:0]);
  endtask

  task automatic issue3(input logic [2:0] a, input logic [2:0] b, input logic c);
    a3 = a; b3 = b; cin3 = c; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
  endtask

  task automatic finish3(input int unsigned expected);
    int lat = 0;
    while (!done3 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w3_latency", lat, 3);
    check("w3_result", {cout3, sum3}, expected[3:0]);
  endtask

  initial begin
    int done_cnt;
    logic [4:0] seen;
    logic [3:0] ra, rb;
    logic rc;

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", ready4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_sum_cout", {cout4, sum4}, 5'h00);
    @(negedge clk);

    // F + 1: done for exactly one cycle, then back to idle.
    issue4(4'hF, 4'h1, 1'b0);
    finish4("f_plus_1", 32'hF + 32'h1);
    @(negedge clk);
    check("f_plus_1_done_width", done4, 1'b0);
    check("f_plus_1_ready_idle", ready4, 1'b1);

    // 5 + A + 1 followed by 3 + 4 accepted in the DONE cycle.
    issue4(4'h5, 4'hA, 1'b1);
    finish4("five_a_cin", 32'h5 + 32'hA + 32'h1);
    check("done_ready", ready4, 1'b1);
    issue4(4'h3, 4'h4, 1'b0);
    finish4("b2b_3_4", 32'h3 + 32'h4);

    // Start during RUN with other operands must be ignored.
    @(negedge clk);
    issue4(4'h6, 4'h5, 1'b0);
    @(negedge clk);
    a4 = 4'h1; b4 = 4'h1; cin4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    done_cnt = 0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      if (done4) begin
        done_cnt++;
        seen = {cout4, sum4};
      end
      @(negedge clk);
    end
    check("midrun_done_count", done_cnt, 1);
    check("midrun_result", seen, 5'h0B);

    // Asynchronous reset on the 2nd RUN edge aborts the operation.
    issue4(4'h9, 4'h9, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_sum_cout", {cout4, sum4}, 5'h00);
    check("abort_ready", ready4, 1'b1);
    check("abort_busy", busy4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (done4) done_cnt++;
      @(negedge clk);
    end
    check("abort_no_done", done_cnt, 0);
    issue4(4'h9, 4'h9, 1'b0);
    finish4("after_abort", 32'h9 + 32'h9);

    // Random operands, with occasional idle gaps between operations.
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
      issue4(ra, rb, rc);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      cin4 = 1'($urandom);
      finish4("random", 32'(ra) + 32'(rb) + 32'(rc));
    end
    @(negedge clk);

    // WIDTH=3 exhaustive, always back-to-back.
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        for (int c = 0; c < 2; c++) begin
          issue3(3'(a), 3'(b), 1'(c));
          finish3(32'(a + b + c));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
